// File: rtl/regfile_sb.sv
// Integer register file with a per-register pending-write scoreboard and writeback bypass.
// Optional operand-wait performance counter is enabled by defining REGFILE_SB_PERF_EN.
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int CW   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rs1_dat,
    output logic [XLEN-1:0] rs2_dat,
    output logic            rs1_dat_val,
    output logic            rs2_dat_val,
    input  logic [AW-1:0]   issue_rd,
    input  logic            issue_rd_val,
    output logic            issue_stall,
    input  logic [AW-1:0]   rd,
    input  logic            rd_val,
    input  logic [XLEN-1:0] rd_dat,
    input  logic            flush,
    output logic            pend_any,
    output logic            wb_err,
    output logic [31:0]     perf_stall_cnt
);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [XLEN-1:0] regs_reg [NREG];
    logic [CW-1:0]   cnt_reg  [NREG];
    logic            wb_err_reg;

    logic [NREG-1:0] inc_vec;
    logic [NREG-1:0] dec_vec;
    logic [NREG-1:0] busy_vec;
    logic            issue_dec;
    logic            rs1_hit;
    logic            rs2_hit;

    // A writeback retiring the issue target frees a slot, so a saturated counter may still accept.
    assign issue_dec   = rd_val && (rd == issue_rd) && (cnt_reg[issue_rd] != '0);
    assign issue_stall = issue_rd_val && (issue_rd != '0)
                         && (cnt_reg[issue_rd] == CNT_MAX) && !issue_dec;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_cnt
            if (gi == 0) begin : g_zero
                assign inc_vec[gi]  = 1'b0;
                assign dec_vec[gi]  = 1'b0;
                assign busy_vec[gi] = 1'b0;
            end else begin : g_reg
                assign inc_vec[gi]  = issue_rd_val && (issue_rd == AW'(gi)) && !issue_stall && !flush;
                assign dec_vec[gi]  = rd_val && (rd == AW'(gi)) && (cnt_reg[gi] != '0);
                assign busy_vec[gi] = (cnt_reg[gi] != '0);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
                cnt_reg[i]  <= '0;
            end
            wb_err_reg <= 1'b0;
        end else begin
            if (rd_val && (rd != '0)) begin
                regs_reg[rd] <= rd_dat;
                if (cnt_reg[rd] == '0) begin
                    wb_err_reg <= 1'b1;
                end
            end
            // Entry 0 is never written after reset, keeping register 0 and its counter at zero.
            for (int i = 1; i < NREG; i++) begin
                cnt_reg[i] <= flush ? '0
                                    : cnt_reg[i] + CW'(inc_vec[i]) - CW'(dec_vec[i]);
            end
        end
    end

    always_comb begin
        rs1_hit     = rd_val && (rd == rs1);
        rs2_hit     = rd_val && (rd == rs2);
        rs1_dat     = regs_reg[rs1];
        rs2_dat     = regs_reg[rs2];
        if (rs1_hit && (rs1 != '0)) begin
            rs1_dat = rd_dat;
        end
        if (rs2_hit && (rs2 != '0)) begin
            rs2_dat = rd_dat;
        end
        // Final once the last outstanding producer is the one writing back right now.
        rs1_dat_val = (cnt_reg[rs1] == '0) || (rs1_hit && (cnt_reg[rs1] == CNT_ONE));
        rs2_dat_val = (cnt_reg[rs2] == '0) || (rs2_hit && (cnt_reg[rs2] == CNT_ONE));
    end

    assign pend_any = |busy_vec;
    assign wb_err   = wb_err_reg;

`ifdef REGFILE_SB_PERF_EN
    logic [31:0] perf_stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt_reg <= '0;
        end else if (issue_rd_val && (!rs1_dat_val || !rs2_dat_val)) begin
            perf_stall_cnt_reg <= perf_stall_cnt_reg + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_reg;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Table-driven bench for regfile_sb: one row per clock, expectations queued at drive time.
// Perf-counter expectations follow REGFILE_SB_PERF_EN as seen by this compile.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1, rs2, issue_rd, rd;
    logic        issue_rd_val, rd_val, flush;
    logic [31:0] rd_dat;
    logic [31:0] rs1_dat, rs2_dat, perf_stall_cnt;
    logic        rs1_dat_val, rs2_dat_val, issue_stall, pend_any, wb_err;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk            (clk),
        .rst            (rst),
        .rs1            (rs1),
        .rs2            (rs2),
        .rs1_dat        (rs1_dat),
        .rs2_dat        (rs2_dat),
        .rs1_dat_val    (rs1_dat_val),
        .rs2_dat_val    (rs2_dat_val),
        .issue_rd       (issue_rd),
        .issue_rd_val   (issue_rd_val),
        .issue_stall    (issue_stall),
        .rd             (rd),
        .rd_val         (rd_val),
        .rd_dat         (rd_dat),
        .flush          (flush),
        .pend_any       (pend_any),
        .wb_err         (wb_err),
        .perf_stall_cnt (perf_stall_cnt)
    );

    typedef struct {
        logic [4:0]  rs1, rs2, ird;
        logic        ival;
        logic [4:0]  rd;
        logic        rval;
        logic [31:0] rdat;
        logic        fl;
        logic [31:0] e1;
        logic        v1;
        logic [31:0] e2;
        logic        v2;
        logic        stall, pend, err;
    } vec_t;

    vec_t        tbl[$];
    vec_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] perf_model = 0;

    function automatic vec_t mk(input logic [4:0] a1, input logic [4:0] a2,
                                input logic [4:0] ird, input logic ival,
                                input logic [4:0] wrd, input logic rval, input logic [31:0] rdat,
                                input logic fl,
                                input logic [31:0] e1, input logic v1,
                                input logic [31:0] e2, input logic v2,
                                input logic stall, input logic pend, input logic err);
        vec_t v;
        v.rs1 = a1; v.rs2 = a2; v.ird = ird; v.ival = ival;
        v.rd = wrd; v.rval = rval; v.rdat = rdat; v.fl = fl;
        v.e1 = e1; v.v1 = v1; v.e2 = e2; v.v2 = v2;
        v.stall = stall; v.pend = pend; v.err = err;
        return v;
    endfunction

    function automatic logic [31:0] perf_ref();
`ifdef REGFILE_SB_PERF_EN
        return perf_model;
`else
        return 32'd0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rs1 = '0; rs2 = '0; issue_rd = '0; issue_rd_val = 1'b0;
        rd = '0; rd_val = 1'b0; rd_dat = '0; flush = 1'b0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        rs1 = v.rs1; rs2 = v.rs2; issue_rd = v.ird; issue_rd_val = v.ival;
        rd = v.rd; rd_val = v.rval; rd_dat = v.rdat; flush = v.fl;
        sb_q.push_back(v);
        #1;
        e = sb_q.pop_front();
        check($sformatf("r%0d.rs1_dat", idx), rs1_dat, e.e1);
        check($sformatf("r%0d.rs1_val", idx), 32'(rs1_dat_val), 32'(e.v1));
        check($sformatf("r%0d.rs2_dat", idx), rs2_dat, e.e2);
        check($sformatf("r%0d.rs2_val", idx), 32'(rs2_dat_val), 32'(e.v2));
        check($sformatf("r%0d.issue_stall", idx), 32'(issue_stall), 32'(e.stall));
        check($sformatf("r%0d.pend_any", idx), 32'(pend_any), 32'(e.pend));
        check($sformatf("r%0d.wb_err", idx), 32'(wb_err), 32'(e.err));
        check($sformatf("r%0d.perf", idx), perf_stall_cnt, perf_ref());
        $display("row %0d: rs1=%0d/%h/%b rs2=%0d/%h/%b issue=%b:%0d wb=%b:%0d:%h fl=%b stall=%b pend=%b err=%b perf=%0d",
                 idx, rs1, rs1_dat, rs1_dat_val, rs2, rs2_dat, rs2_dat_val, issue_rd_val, issue_rd,
                 rd_val, rd, rd_dat, flush, issue_stall, pend_any, wb_err, perf_stall_cnt);
        if (e.ival && (!e.v1 || !e.v2)) perf_model++;
    endtask

    initial begin
        //              rs1 rs2 ird ival rd rv rdat          fl e1            v1 e2            v2 st pd er
        tbl.push_back(mk(5,  0,  0, 0,   0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        1, 0, 0, 0));
        tbl.push_back(mk(3,  0,  3, 1,   0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        1, 0, 0, 0));
        tbl.push_back(mk(3,  0,  0, 0,   0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 1, 0));
        tbl.push_back(mk(3,  0,  0, 0,   3, 1, 32'hDEADBEEF, 0, 32'hDEADBEEF, 1, 32'h0,        1, 0, 1, 0));
        tbl.push_back(mk(3,  3,  0, 0,   0, 0, 32'h0,        0, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 0, 0, 0));
        tbl.push_back(mk(7,  0,  7, 1,   0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        1, 0, 0, 0));
        tbl.push_back(mk(7,  0,  7, 1,   0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 1, 0));
        tbl.push_back(mk(7,  0,  7, 1,   0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 1, 0));
        tbl.push_back(mk(7,  0,  7, 1,   0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 1, 1, 0));
        tbl.push_back(mk(7,  0,  7, 1,   7, 1, 32'h11,       0, 32'h11,       0, 32'h0,        1, 0, 1, 0));
        tbl.push_back(mk(7,  0,  0, 0,   7, 1, 32'h22,       0, 32'h22,       0, 32'h0,        1, 0, 1, 0));
        tbl.push_back(mk(7,  0,  0, 0,   7, 1, 32'h33,       0, 32'h33,       0, 32'h0,        1, 0, 1, 0));
        tbl.push_back(mk(7,  0,  0, 0,   7, 1, 32'h7A,       0, 32'h7A,       1, 32'h0,        1, 0, 1, 0));
        tbl.push_back(mk(7,  7,  0, 0,   0, 0, 32'h0,        0, 32'h7A,       1, 32'h7A,       1, 0, 0, 0));
        tbl.push_back(mk(9,  0,  9, 1,   0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        1, 0, 0, 0));
        tbl.push_back(mk(9,  0,  9, 1,   9, 1, 32'h99,       0, 32'h99,       1, 32'h0,        1, 0, 1, 0));
        tbl.push_back(mk(9,  0,  0, 1,   0, 0, 32'h0,        0, 32'h99,       0, 32'h0,        1, 0, 1, 0));
        tbl.push_back(mk(9,  0,  0, 1,   9, 1, 32'hAA,       0, 32'hAA,       1, 32'h0,        1, 0, 1, 0));
        tbl.push_back(mk(9,  0,  0, 0,   0, 1, 32'h55,       0, 32'hAA,       1, 32'h0,        1, 0, 0, 0));
        tbl.push_back(mk(4,  0,  0, 0,   4, 1, 32'h44,       0, 32'h44,       1, 32'h0,        1, 0, 0, 0));
        tbl.push_back(mk(4,  0,  6, 1,   0, 0, 32'h0,        0, 32'h44,       1, 32'h0,        1, 0, 0, 1));
        tbl.push_back(mk(6,  0,  6, 1,   0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 1, 1));
        tbl.push_back(mk(6,  0,  6, 1,   6, 1, 32'h66,       1, 32'h66,       0, 32'h0,        1, 0, 1, 1));
        tbl.push_back(mk(6,  0,  0, 0,   0, 0, 32'h0,        0, 32'h66,       1, 32'h0,        1, 0, 0, 1));
        tbl.push_back(mk(0, 10, 10, 1,   0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        1, 0, 0, 1));
        tbl.push_back(mk(0, 10, 11, 1,   0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 0, 1, 1));
        tbl.push_back(mk(0, 10, 11, 1,   0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 0, 1, 1));
        tbl.push_back(mk(0, 10, 11, 1,   0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 0, 1, 1));
        tbl.push_back(mk(0, 10, 11, 1,   0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 1, 1, 1));
        tbl.push_back(mk(0, 10, 11, 1,   0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 1, 1, 1));
        tbl.push_back(mk(0,  0,  0, 0,   0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        1, 0, 1, 1));

        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Reset asserted alongside an issue and a writeback: reset wins.
        @(negedge clk);
        rst = 1'b1; issue_rd = 5'd12; issue_rd_val = 1'b1;
        rd = 5'd5; rd_val = 1'b1; rd_dat = 32'h5A5A5A5A; flush = 1'b0;
        rs1 = 5'd0; rs2 = 5'd10;
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        rs1 = 5'd5; rs2 = 5'd4;
        #1;
        perf_model = 0;
        check("rst.rs1_dat", rs1_dat, 32'h0);
        check("rst.rs2_dat", rs2_dat, 32'h0);
        check("rst.rs1_val", 32'(rs1_dat_val), 32'd1);
        check("rst.rs2_val", 32'(rs2_dat_val), 32'd1);
        check("rst.pend_any", 32'(pend_any), 32'd0);
        check("rst.wb_err", 32'(wb_err), 32'd0);
        check("rst.perf", perf_stall_cnt, perf_ref());
        $display("mid-reset: rs1=%h rs2=%h pend=%b err=%b perf=%0d",
                 rs1_dat, rs2_dat, pend_any, wb_err, perf_stall_cnt);

        // Register 12 must not have been reserved by the issue dropped under reset.
        rs1 = 5'd12;
        #1;
        check("rst.r12_val", 32'(rs1_dat_val), 32'd1);
        $display("post-reset: rs1=12 val=%b", rs1_dat_val);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
